// File: rtl/uart_rx_frame_if.sv
// Serial receive side bundle: the rx pin plus the received-byte outputs.
// No latency of its own; pure wiring between the pin, receiver and consumer.
// No backpressure: the consumer must take po_data in the po_flag cycle.
interface uart_rx_frame_if;
   logic       rx;
   logic [7:0] po_data;
   logic       po_flag;
   logic       frame_err;
   logic       busy;

   // receiver side
   modport master (
      input  rx,
      output po_data,
      output po_flag,
      output frame_err,
      output busy
   );

   // line driver / byte consumer side
   modport slave (
      output rx,
      input  po_data,
      input  po_flag,
      input  frame_err,
      input  busy
   );
endinterface

// File: rtl/uart_rx_frame.sv
// 8N1 UART receiver: deserialises rx into bytes, flags framing errors.
// Latency: po_flag about 9.5 bit times (9*BIT_CNT_MAX + MID + 4 cycles) after the start edge.
// No backpressure: po_flag / frame_err are single-cycle pulses that cannot be stalled.
module uart_rx_frame #(
   parameter int CLK_FREQ = 50000000,
   parameter int BAUD     = 9600
) (
   input logic             sys_clk,
   input logic             sys_rst_n,
   uart_rx_frame_if.master uif
);

   localparam int          BIT_CNT_MAX = CLK_FREQ / BAUD;
   localparam int          MID         = BIT_CNT_MAX / 2;
   localparam logic [12:0] BAUD_LAST   = 13'(BIT_CNT_MAX - 1);
   localparam logic [12:0] BAUD_MID    = 13'(MID);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [12:0] baud_cnt_q, baud_cnt_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  shift_q, shift_d;
   logic [7:0]  po_data_q, po_data_d;
   logic        po_flag_q, po_flag_d;
   logic        frame_err_q, frame_err_d;
   logic        busy_q, busy_d;
   logic        rx_s1_q, rx_s1_d;
   logic        rx_s2_q, rx_s2_d;
   logic        rx_s3_q, rx_s3_d;
   // sync_vld marks which synchronizer stages hold real pin samples rather
   // than reset values; armed is set once a genuine high has been seen, so a
   // line that is already low when reset releases cannot fake a start edge.
   logic [1:0]  sync_vld_q, sync_vld_d;
   logic        armed_q, armed_d;
   logic        fall;

   // Next-state logic: synchronizer, edge detect, bit timing and frame FSM.
   always_comb begin
      state_d     = state_q;
      baud_cnt_d  = baud_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      po_data_d   = po_data_q;
      po_flag_d   = 1'b0;
      frame_err_d = 1'b0;

      rx_s1_d    = uif.rx;
      rx_s2_d    = rx_s1_q;
      rx_s3_d    = rx_s2_q;
      sync_vld_d = {sync_vld_q[0], 1'b1};
      armed_d    = armed_q | (sync_vld_q[1] & rx_s2_q);
      fall       = armed_q & rx_s3_q & ~rx_s2_q;

      if (state_q != IDLE) begin
         baud_cnt_d = (baud_cnt_q == BAUD_LAST) ? 13'd0 : baud_cnt_q + 13'd1;
      end

      case (state_q)
         IDLE: begin
            baud_cnt_d = 13'd0;
            if (fall) begin
               state_d = START;
            end
         end
         START: begin
            if (baud_cnt_q == BAUD_MID && rx_s2_q) begin
               // line back high mid start bit: glitch, not a frame
               state_d    = IDLE;
               baud_cnt_d = 13'd0;
            end else if (baud_cnt_q == BAUD_LAST) begin
               state_d   = DATA;
               bit_cnt_d = 3'd0;
            end
         end
         DATA: begin
            if (baud_cnt_q == BAUD_MID) begin
               shift_d = {rx_s2_q, shift_q[7:1]};
            end
            if (baud_cnt_q == BAUD_LAST) begin
               if (bit_cnt_q == 3'd7) begin
                  state_d = STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
         end
         STOP: begin
            if (baud_cnt_q == BAUD_MID) begin
               if (rx_s2_q) begin
                  po_data_d = shift_q;
                  po_flag_d = 1'b1;
               end else begin
                  frame_err_d = 1'b1;
               end
               // leave at mid-stop so an immediately following start edge is seen
               state_d    = IDLE;
               baud_cnt_d = 13'd0;
            end
         end
         default: begin
            state_d    = IDLE;
            baud_cnt_d = 13'd0;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state_q     <= IDLE;
         baud_cnt_q  <= 13'd0;
         bit_cnt_q   <= 3'd0;
         shift_q     <= 8'h00;
         po_data_q   <= 8'h00;
         po_flag_q   <= 1'b0;
         frame_err_q <= 1'b0;
         busy_q      <= 1'b0;
         rx_s1_q     <= 1'b1;
         rx_s2_q     <= 1'b1;
         rx_s3_q     <= 1'b1;
         sync_vld_q  <= 2'b00;
         armed_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         baud_cnt_q  <= baud_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         po_data_q   <= po_data_d;
         po_flag_q   <= po_flag_d;
         frame_err_q <= frame_err_d;
         busy_q      <= busy_d;
         rx_s1_q     <= rx_s1_d;
         rx_s2_q     <= rx_s2_d;
         rx_s3_q     <= rx_s3_d;
         sync_vld_q  <= sync_vld_d;
         armed_q     <= armed_d;
      end
   end

   assign uif.po_data   = po_data_q;
   assign uif.po_flag   = po_flag_q;
   assign uif.frame_err = frame_err_q;
   assign uif.busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame at a scaled baud (100 cycles per bit).
// Frames are built bit by bit on the pin; outputs are logged as events and
// compared with the byte / error outcome expected for each frame sent.
module tb_uart_rx_frame;

   localparam int CLK_FREQ = 960000;
   localparam int BAUD     = 9600;
   localparam int BIT      = CLK_FREQ / BAUD;
   localparam int MID      = BIT / 2;
   localparam int LAT      = 9 * BIT + MID + 4;

   logic sys_clk   = 1'b0;
   logic sys_rst_n = 1'b0;

   uart_rx_frame_if uif();

   uart_rx_frame #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .uif       (uif)
   );

   always #5 sys_clk = ~sys_clk;

   int cyc = 0;
   always @(posedge sys_clk) cyc <= cyc + 1;

   // event log: one entry per po_flag or frame_err cycle
   bit         ev_err[$];
   logic [7:0] ev_dat[$];
   int         ev_cyc[$];
   int         busy_cycles = 0;

   always @(negedge sys_clk) begin
      if (uif.po_flag === 1'b1) begin
         ev_err.push_back(1'b0);
         ev_dat.push_back(uif.po_data);
         ev_cyc.push_back(cyc);
      end
      if (uif.frame_err === 1'b1) begin
         ev_err.push_back(1'b1);
         ev_dat.push_back(8'h00);
         ev_cyc.push_back(cyc);
      end
      if (uif.busy === 1'b1) busy_cycles = busy_cycles + 1;
   end

   int n_cmp = 0;
   int n_bad = 0;

   // line drivers; each is entered and left 1 time unit after a rising edge
   task automatic hold(input logic v, input int per);
      uif.rx = v;
      repeat (per) @(posedge sys_clk);
      #1;
   endtask

   task automatic idle(input int n);
      hold(1'b1, n);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop, input int per,
                             output int t0);
      t0 = cyc;
      hold(1'b0, per);
      for (int i = 0; i < 8; i++) hold(b[i], per);
      hold(stop, per);
   endtask

   task automatic test_reset();
      uif.rx    = 1'b1;
      sys_rst_n = 1'b0;
      repeat (4) @(posedge sys_clk);
      #1;
      n_cmp++; if (uif.po_data !== 8'h00) begin n_bad++; $display("FAIL reset_po_data got %h exp 00", uif.po_data); end
      n_cmp++; if (uif.po_flag !== 1'b0) begin n_bad++; $display("FAIL reset_po_flag got %b exp 0", uif.po_flag); end
      n_cmp++; if (uif.frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_frame_err got %b exp 0", uif.frame_err); end
      n_cmp++; if (uif.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b exp 0", uif.busy); end
      sys_rst_n = 1'b1;
      idle(20);
   endtask

   task automatic test_rx_low_at_reset();
      int eb, bb;
      uif.rx    = 1'b0;
      sys_rst_n = 1'b0;
      repeat (3) @(posedge sys_clk);
      #1;
      sys_rst_n = 1'b1;
      eb = ev_err.size();
      bb = busy_cycles;
      hold(1'b0, 300);
      idle(50);
      n_cmp++; if (busy_cycles - bb != 0) begin n_bad++; $display("FAIL rx_low_reset_busy got %0d busy cycles exp 0", busy_cycles - bb); end
      n_cmp++; if (ev_err.size() - eb != 0) begin n_bad++; $display("FAIL rx_low_reset_events got %0d exp 0", ev_err.size() - eb); end
   endtask

   task automatic test_basic();
      int eb, t0;
      eb = ev_err.size();
      send_frame(8'h55, 1'b1, BIT, t0);
      n_cmp++; if (ev_err.size() != eb + 1) begin n_bad++; $display("FAIL basic55_count got %0d exp 1", ev_err.size() - eb); end
      n_cmp++; if (ev_err.size() <= eb || ev_err[eb] !== 1'b0 || ev_dat[eb] !== 8'h55) begin n_bad++; $display("FAIL basic55_data got %h exp 55 flag", uif.po_data); end
      n_cmp++; if (ev_err.size() <= eb || ev_cyc[eb] - t0 < LAT - 1 || ev_cyc[eb] - t0 > LAT + 1) begin n_bad++; $display("FAIL basic55_latency got %0d exp %0d", (ev_err.size() > eb) ? ev_cyc[eb] - t0 : -1, LAT); end
      n_cmp++; if (uif.busy !== 1'b0) begin n_bad++; $display("FAIL basic55_busy_after got %b exp 0", uif.busy); end
      idle(10);
      eb = ev_err.size();
      send_frame(8'hA3, 1'b1, BIT, t0);
      idle(5);
      n_cmp++; if (ev_err.size() != eb + 1 || ev_err[eb] !== 1'b0 || ev_dat[eb] !== 8'hA3) begin n_bad++; $display("FAIL basicA3_data got %h exp A3", uif.po_data); end
      n_cmp++; if (uif.po_data !== 8'hA3) begin n_bad++; $display("FAIL basicA3_hold got %h exp A3", uif.po_data); end
   endtask

   task automatic test_frame_err();
      int eb, t0;
      eb = ev_err.size();
      send_frame(8'h3C, 1'b0, BIT, t0);
      idle(20);
      n_cmp++; if (ev_err.size() != eb + 1 || ev_err[eb] !== 1'b1) begin n_bad++; $display("FAIL frame_err_pulse got %0d events exp one error", ev_err.size() - eb); end
      n_cmp++; if (uif.po_data !== 8'hA3) begin n_bad++; $display("FAIL frame_err_po_data got %h exp A3", uif.po_data); end
   endtask

   task automatic test_false_start();
      int eb, bb;
      eb = ev_err.size();
      bb = busy_cycles;
      hold(1'b0, 20);
      idle(300);
      n_cmp++; if (busy_cycles - bb < MID - 2 || busy_cycles - bb > MID + 3) begin n_bad++; $display("FAIL false_start_busy got %0d exp about %0d", busy_cycles - bb, MID + 1); end
      n_cmp++; if (ev_err.size() != eb) begin n_bad++; $display("FAIL false_start_events got %0d exp 0", ev_err.size() - eb); end
   endtask

   task automatic test_back_to_back();
      int eb, t0, t1;
      eb = ev_err.size();
      send_frame(8'h00, 1'b1, BIT, t0);
      send_frame(8'hFF, 1'b1, BIT, t1);
      idle(10);
      n_cmp++; if (ev_err.size() != eb + 2) begin n_bad++; $display("FAIL b2b_count got %0d exp 2", ev_err.size() - eb); end
      n_cmp++; if (ev_err.size() < eb + 2 || ev_err[eb] !== 1'b0 || ev_dat[eb] !== 8'h00 || ev_err[eb+1] !== 1'b0 || ev_dat[eb+1] !== 8'hFF) begin n_bad++; $display("FAIL b2b_data got %h exp 00 then FF", uif.po_data); end
      n_cmp++; if (ev_err.size() < eb + 2 || ev_cyc[eb+1] - ev_cyc[eb] < 10*BIT - 2 || ev_cyc[eb+1] - ev_cyc[eb] > 10*BIT + 2) begin n_bad++; $display("FAIL b2b_spacing got %0d exp %0d", (ev_err.size() >= eb + 2) ? ev_cyc[eb+1] - ev_cyc[eb] : -1, 10*BIT); end
   endtask

   task automatic test_reset_mid_frame();
      int eb, t0;
      logic [7:0] b;
      b  = 8'h96;
      eb = ev_err.size();
      hold(1'b0, BIT);
      for (int i = 0; i < 4; i++) hold(b[i], BIT);
      hold(b[4], 30);
      sys_rst_n = 1'b0;
      @(posedge sys_clk);
      #1;
      sys_rst_n = 1'b1;
      n_cmp++; if (uif.busy !== 1'b0) begin n_bad++; $display("FAIL midreset_busy got %b exp 0", uif.busy); end
      idle(300);
      n_cmp++; if (ev_err.size() != eb) begin n_bad++; $display("FAIL midreset_events got %0d exp 0", ev_err.size() - eb); end
      n_cmp++; if (uif.po_data !== 8'h00) begin n_bad++; $display("FAIL midreset_po_data got %h exp 00", uif.po_data); end
      send_frame(8'h81, 1'b1, BIT, t0);
      idle(5);
      n_cmp++; if (ev_err.size() != eb + 1 || ev_err[eb] !== 1'b0 || ev_dat[eb] !== 8'h81) begin n_bad++; $display("FAIL midreset_next got %h exp 81", uif.po_data); end
   endtask

   task automatic test_baud_tolerance();
      int eb, t0;
      int pers[2];
      pers[0] = BIT - BIT / 50;
      pers[1] = BIT + BIT / 50;
      for (int k = 0; k < 2; k++) begin
         eb = ev_err.size();
         send_frame(8'h5A, 1'b1, pers[k], t0);
         idle(20);
         n_cmp++; if (ev_err.size() != eb + 1 || ev_err[eb] !== 1'b0 || ev_dat[eb] !== 8'h5A) begin n_bad++; $display("FAIL tolerance_%0d got %h exp 5A", pers[k], uif.po_data); end
      end
   endtask

   task automatic test_random();
      int eb, t0, gap, per;
      bit         exp_err[$];
      logic [7:0] exp_dat[$];
      logic [7:0] b, last_good;
      logic       stop;
      eb        = ev_err.size();
      last_good = uif.po_data;
      for (int i = 0; i < 16; i++) begin
         b    = 8'($urandom_range(0, 255));
         stop = ($urandom_range(0, 3) != 0);
         per  = $urandom_range(BIT - BIT / 50, BIT + BIT / 50);
         exp_err.push_back(!stop);
         exp_dat.push_back(b);
         if (stop) last_good = b;
         send_frame(b, stop, per, t0);
         gap = stop ? $urandom_range(0, 20) : $urandom_range(5, 20);
         idle(gap);
      end
      idle(50);
      n_cmp++; if (ev_err.size() - eb != 16) begin n_bad++; $display("FAIL random_count got %0d exp 16", ev_err.size() - eb); end
      for (int i = 0; i < 16; i++) begin
         n_cmp++;
         if (eb + i >= ev_err.size() || ev_err[eb+i] !== exp_err[i] || (!exp_err[i] && ev_dat[eb+i] !== exp_dat[i])) begin
            n_bad++;
            $display("FAIL random_frame%0d got err=%b dat=%h exp err=%b dat=%h", i,
                     (eb + i < ev_err.size()) ? ev_err[eb+i] : 1'bx,
                     (eb + i < ev_err.size()) ? ev_dat[eb+i] : 8'hxx, exp_err[i], exp_dat[i]);
         end
      end
      n_cmp++; if (uif.po_data !== last_good) begin n_bad++; $display("FAIL random_po_data got %h exp %h", uif.po_data, last_good); end
   endtask

   initial begin
      uif.rx = 1'b1;
      @(posedge sys_clk);
      #1;
      test_reset();
      test_rx_low_at_reset();
      test_basic();
      test_frame_err();
      test_false_start();
      test_back_to_back();
      test_reset_mid_frame();
      test_baud_tolerance();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #3ms;
      $display("FAIL watchdog timeout after %0d cycles", cyc);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
- UART receiver for the RS232 path. It deserialises 8N1 frames from the `rx` pin into bytes: 1 start bit, 8 data bits LSB first, 1 stop bit.
- It presents each good byte with a one-cycle valid pulse and reports framing errors separately.
- It is the receive end of the link whose transmitter is driven by a start flag and an 8-bit data word. It sits between the external serial pin and downstream loopback/consumer logic.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 9600, line rate in bit/s.
- Derived localparam, not overridable: BIT_CNT_MAX = CLK_FREQ/BAUD (integer division) = 5208 cycles per bit.
- Derived localparam, not overridable: MID = BIT_CNT_MAX/2 = 2604.

Ports:
- sys_clk  input  1  system clock; all logic on rising edge.
- sys_rst_n  input  1  reset, synchronous, active-low.
- rx  input  1  asynchronous serial line; idle high.
- po_data  output  8  last correctly received byte.
- po_flag  output  1  one-cycle pulse; po_data is valid and new in this cycle.
- frame_err  output  1  one-cycle pulse; stop bit sampled low, byte discarded.
- busy  output  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Reset (sys_rst_n low at a clock edge):
  - state = IDLE; baud_cnt = 0; bit_cnt = 0; shift register = 0.
  - po_data = 8'h00; po_flag = 0; frame_err = 0; busy = 0.
  - Synchronizer flops = 1.
- Input conditioning:
  - rx passes through 2 flops (rx_s1, rx_s2), then a third flop rx_s3.
  - fall = rx_s3 & ~rx_s2.
  - The 2-cycle synchronizer latency is inherent.
- Counters:
  - baud_cnt is 13 bits. It counts 0..BIT_CNT_MAX-1 while not IDLE and wraps to 0.
  - baud_cnt is held at 0 in IDLE.
  - bit_cnt is 3 bits and indexes data bits 0..7.
- States:
  - IDLE:
    - fall -> START, baud_cnt = 0.
    - rx low at reset release without a falling edge does not start a frame.
  - START:
    - At baud_cnt == MID, if rx_s2 == 1 -> false start: go to IDLE with no pulse of any kind.
    - At baud_cnt == BIT_CNT_MAX-1 -> DATA, bit_cnt = 0.
  - DATA:
    - At baud_cnt == MID, shift right with rx_s2 entering bit 7, so the first data bit ends in bit 0.
    - At baud_cnt == BIT_CNT_MAX-1: if bit_cnt == 7 -> STOP, else bit_cnt += 1.
  - STOP:
    - At baud_cnt == MID, if rx_s2 == 1: po_data <= shift register and po_flag = 1 for the next cycle only.
    - At baud_cnt == MID, if rx_s2 == 0: frame_err = 1 for one cycle and po_data is unchanged.
    - In either case the state returns to IDLE at the same edge. Leaving at mid-stop lets a start edge that follows immediately be caught.
- Falling edges seen while not IDLE are ignored.
- po_flag and frame_err are never high together. Neither is ever high for more than 1 cycle.
- po_data holds its value between frames.
- Timing: with rx changing on a clock edge, po_flag rises 9*BIT_CNT_MAX + MID + 4 cycles (±1) after the rx falling edge at the pin, i.e. about 9.5 bit times.
- Reset mid-frame: abort immediately to the reset values. The partial byte is lost and no pulse is produced.
- Tolerance: frames from a transmitter up to ±2% off nominal baud must be received correctly.

Test Plan:
- Send 0x55 at 5208 cycles/bit, stop = 1 -> one po_flag pulse with po_data = 8'h55, frame_err stays 0, busy low after the pulse. Then send 0xA3 -> po_data = 8'hA3.
- Send 0x3C with the stop bit driven low -> frame_err pulses once, po_flag stays 0, po_data keeps its previous value (8'hA3).
- Drive rx low for 1000 cycles, then high -> busy high for about 2604 cycles, then low; no po_flag, no frame_err.
- Send 0x00 then 0xFF back-to-back with no idle gap -> two po_flag pulses, po_data = 8'h00 then 8'hFF, spaced 10*5208 ±2 cycles.
- Assert sys_rst_n low for 1 cycle during data bit 4 of 0x96, then send a full frame 0x81 -> no output for the aborted frame; one po_flag with po_data = 8'h81.
- Send 0x5A at 5104 and at 5312 cycles/bit (±2%) -> po_data = 8'h5A in both cases, no frame_err.
